gpio_ctrl: RTL and testbench

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_ctrl.sv | 148 ++++++++++++++
 tb/tb_gpio_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - PicoBlaze-attached 8-bit GPIO port with edge interrupts
//
// Six registers starting at BASE_ADDR: DOUT, OEN, DIN, MASK, STATUS, EDGE.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   port_id, write_strobe - CPU address and one-cycle write qualifier
//   out_port / in_port    - CPU write data / registered read data
//   interrupt             - registered interrupt request
//   interrupt_ack         - one-cycle acknowledge from the CPU
//   gpio_oen              - per-bit output enable, active low (1 = tristate)
//   gpio_data_out         - pin drive values
//   gpio_data_in          - raw asynchronous pin values
module gpio_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  output logic [7:0] gpio_oen,
  output logic [7:0] gpio_data_out,
  input  logic [7:0] gpio_data_in
);

  localparam logic [7:0] OFF_DOUT   = 8'd0;
  localparam logic [7:0] OFF_OEN    = 8'd1;
  localparam logic [7:0] OFF_DIN    = 8'd2;
  localparam logic [7:0] OFF_MASK   = 8'd3;
  localparam logic [7:0] OFF_STATUS = 8'd4;
  localparam logic [7:0] OFF_EDGE   = 8'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  logic [7:0] dout_q,    dout_d;
  logic [7:0] oen_q,     oen_d;
  logic [7:0] mask_q,    mask_d;
  logic [7:0] status_q,  status_d;
  logic [7:0] edge_q,    edge_d;
  logic [7:0] s1_q,      s1_d;
  logic [7:0] s2_q,      s2_d;
  logic [7:0] s3_q,      s3_d;
  logic [7:0] in_port_q, in_port_d;
  logic       interrupt_q, interrupt_d;
  state_t     state_q,   state_d;

  // Offset relative to the base; anything at or above 6 is unmapped.
  logic [7:0] offset;
  logic [7:0] edge_hit;
  logic [7:0] w1c;
  logic       irq_pending;

  assign offset = port_id - BASE_ADDR;

  always_comb begin
    dout_d      = dout_q;
    oen_d       = oen_q;
    mask_d      = mask_q;
    edge_d      = edge_q;
    w1c         = 8'h00;
    in_port_d   = 8'h00;
    state_d     = state_q;

    // Synchronizer chain; s3 holds the previous s2 for edge detection.
    s1_d = gpio_data_in;
    s2_d = s1_q;
    s3_d = s2_q;

    if (write_strobe) begin
      case (offset)
        OFF_DOUT:   dout_d = out_port;
        OFF_OEN:    oen_d  = out_port;
        OFF_MASK:   mask_d = out_port;
        OFF_STATUS: w1c    = out_port;
        OFF_EDGE:   edge_d = out_port;
        default:    ;
      endcase
    end

    // Polarity is applied to the s2/s3 pair only, so changing EDGE alone
    // never produces a hit. Sets are ORed in after the clear so set wins.
    edge_hit = (edge_q & s2_q & ~s3_q) | (~edge_q & ~s2_q & s3_q);
    status_d = (status_q & ~w1c) | edge_hit;

    case (offset)
      OFF_DOUT:   in_port_d = dout_q;
      OFF_OEN:    in_port_d = oen_q;
      OFF_DIN:    in_port_d = s2_q;
      OFF_MASK:   in_port_d = mask_q;
      OFF_STATUS: in_port_d = status_q;
      OFF_EDGE:   in_port_d = edge_q;
      default:    in_port_d = 8'h00;
    endcase

    irq_pending = |(status_q & mask_q);

    case (state_q)
      ST_IDLE:    if (irq_pending)   state_d = ST_PEND;
      ST_PEND:    if (interrupt_ack) state_d = ST_SERVICE;
      ST_SERVICE: if (!irq_pending)  state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase

    // Registered request that mirrors the PEND state.
    interrupt_d = (state_d == ST_PEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q      <= 8'h00;
      oen_q       <= 8'hFF;
      mask_q      <= 8'h00;
      status_q    <= 8'h00;
      edge_q      <= 8'hFF;
      s1_q        <= 8'h00;
      s2_q        <= 8'h00;
      s3_q        <= 8'h00;
      in_port_q   <= 8'h00;
      interrupt_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      dout_q      <= dout_d;
      oen_q       <= oen_d;
      mask_q      <= mask_d;
      status_q    <= status_d;
      edge_q      <= edge_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      in_port_q   <= in_port_d;
      interrupt_q <= interrupt_d;
      state_q     <= state_d;
    end
  end

  assign in_port       = in_port_q;
  assign interrupt     = interrupt_q;
  assign gpio_oen      = oen_q;
  assign gpio_data_out = dout_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - self-checking bench for gpio_ctrl
module tb_gpio_ctrl;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] gpio_oen;
  logic [7:0] gpio_data_out;
  logic [7:0] gpio_data_in;

  gpio_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .gpio_oen      (gpio_oen),
    .gpio_data_out (gpio_data_out),
    .gpio_data_in  (gpio_data_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: register file indexed by offset (slot 2 unused, DIN
  // comes from the pin sample history), samples[0] = newest sampled pins.
  logic [7:0] m_regs [0:5];
  logic [7:0] samples [0:2];
  int         m_phase;     // 0 quiet, 1 requesting, 2 being serviced
  logic [7:0] m_in;
  logic       m_irq;

  function automatic logic [7:0] m_read(input logic [7:0] addr);
    logic [7:0] off;
    off = addr - BASE;
    if (off == 8'd2) return samples[1];
    if (off < 8'd6)  return m_regs[off];
    return 8'h00;
  endfunction

  task automatic model_edge();
    logic [7:0] off, prev, cur, hits;
    bit         pending;
    if (reset) begin
      m_regs[0] = 8'h00; m_regs[1] = 8'hFF; m_regs[2] = 8'h00;
      m_regs[3] = 8'h00; m_regs[4] = 8'h00; m_regs[5] = 8'hFF;
      for (int i = 0; i < 3; i++) samples[i] = 8'h00;
      m_phase = 0;
      m_in    = 8'h00;
      m_irq   = 1'b0;
      return;
    end
    m_in    = m_read(port_id);
    cur     = samples[1];
    prev    = samples[2];
    hits    = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (m_regs[5][b] && cur[b] && !prev[b]) hits[b] = 1'b1;
      if (!m_regs[5][b] && !cur[b] && prev[b]) hits[b] = 1'b1;
    end
    pending = (m_regs[4] & m_regs[3]) != 8'h00;
    if (m_phase == 0 && pending) m_phase = 1;
    else if (m_phase == 1 && interrupt_ack) m_phase = 2;
    else if (m_phase == 2 && !pending) m_phase = 0;
    off = port_id - BASE;
    if (write_strobe) begin
      if (off == 8'd4) m_regs[4] = m_regs[4] & ~out_port;
      else if (off < 8'd6 && off != 8'd2) m_regs[off] = out_port;
    end
    m_regs[4] = m_regs[4] | hits;
    samples[2] = samples[1];
    samples[1] = samples[0];
    samples[0] = gpio_data_in;
    m_irq = (m_phase == 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check8("dout",    gpio_data_out,      m_regs[0]);
    check8("oen",     gpio_oen,           m_regs[1]);
    check8("irq",     {7'b0, interrupt},  {7'b0, m_irq});
    check8("in_port", in_port,            m_in);
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] data);
    port_id      = BASE + off;
    out_port     = data;
    write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, output logic [7:0] data);
    port_id = BASE + off;
    step();
    data = in_port;
  endtask

  logic [7:0] v;

  initial begin
    reset         = 1'b1;
    port_id       = 8'h00;
    write_strobe  = 1'b0;
    out_port      = 8'h00;
    interrupt_ack = 1'b0;
    gpio_data_in  = 8'h00;
    step();
    step();
    reset = 1'b0;
    check8("rst_oen",  gpio_oen,          8'hFF);
    check8("rst_dout", gpio_data_out,     8'h00);
    check8("rst_irq",  {7'b0, interrupt}, 8'h00);
    check8("rst_in",   in_port,           8'h00);

    // DOUT / OEN write and readback
    wr(8'd0, 8'hA5);
    check8("dout_a5", gpio_data_out, 8'hA5);
    wr(8'd1, 8'h0F);
    check8("oen_0f", gpio_oen, 8'h0F);
    rd(8'd0, v); check8("rd_dout", v, 8'hA5);
    rd(8'd1, v); check8("rd_oen",  v, 8'h0F);
    rd(8'd5, v); check8("rd_edge_rst", v, 8'hFF);

    // Rising edge on pin 0 with MASK=1
    wr(8'd5, 8'hFF);
    wr(8'd3, 8'h01);
    gpio_data_in = 8'h01;
    port_id = BASE + 8'd2;
    step(); step(); step();
    check8("din0", in_port & 8'h01, 8'h01);
    rd(8'd4, v);
    check8("status01", v, 8'h01);
    check8("irq_set", {7'b0, interrupt}, 8'h01);

    // Acknowledge, clear, re-arm
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    check8("irq_ack", {7'b0, interrupt}, 8'h00);
    wr(8'd4, 8'h01);
    step();
    rd(8'd4, v); check8("status_clr", v, 8'h00);
    gpio_data_in = 8'h00;
    repeat (4) step();
    check8("no_irq_fall", {7'b0, interrupt}, 8'h00);
    gpio_data_in = 8'h01;
    repeat (4) step();
    check8("irq_again", {7'b0, interrupt}, 8'h01);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    wr(8'd4, 8'hFF);
    repeat (2) step();

    // Set beats clear: falling edge on pin 3 coincides with W1C
    wr(8'd5, 8'hF7);
    gpio_data_in = 8'h09;
    repeat (4) step();
    rd(8'd4, v); check8("no_rise_set3", v & 8'h08, 8'h00);
    gpio_data_in = 8'h01;
    port_id = BASE;
    step(); step();
    wr(8'd4, 8'h08);
    rd(8'd4, v); check8("set_wins", v & 8'h08, 8'h08);
    wr(8'd4, 8'h08);
    rd(8'd4, v); check8("clr3", v & 8'h08, 8'h00);

    // Masked edge on pin 5, then unmask
    wr(8'd5, 8'hFF);
    gpio_data_in = 8'h21;
    repeat (4) step();
    check8("masked_irq", {7'b0, interrupt}, 8'h00);
    rd(8'd4, v); check8("status20", v, 8'h20);
    wr(8'd3, 8'h20);
    step();
    check8("unmask_irq", {7'b0, interrupt}, 8'h01);

    // Reset while requesting
    wr(8'd0, 8'h3C);
    check8("dout3c", gpio_data_out, 8'h3C);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check8("rst_pend_irq",  {7'b0, interrupt}, 8'h00);
    check8("rst_pend_oen",  gpio_oen,          8'hFF);
    check8("rst_pend_dout", gpio_data_out,     8'h00);
    rd(8'd4, v); check8("rst_pend_stat", v, 8'h00);
    rd(8'd6, v); check8("unmapped6",     v, 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) port_id = 8'($urandom);
      else port_id = BASE + 8'($urandom_range(0, 7));
      write_strobe  = ($urandom_range(0, 3) == 0);
      out_port      = 8'($urandom);
      interrupt_ack = ($urandom_range(0, 5) == 0);
      reset         = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0)
        gpio_data_in = gpio_data_in ^ (8'h01 << $urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    write_strobe = 1'b0;
    interrupt_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
